// File: rtl/adder_err_sweep.sv
// Exhaustive sweep controller that scores an external approximate adder against the exact sum.
// Define ERR_SWEEP_BITFLIP_EN to add per-sum-bit mismatch counters on bit_err_cnt.

module adder_err_sweep #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 2*WIDTH+1,
   parameter int ACC_W = 3*WIDTH+1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dut_a,
   output logic [WIDTH-1:0] dut_b,
   input  logic [WIDTH:0]   dut_sum,
   output logic [CNT_W-1:0] err_count,
   output logic [WIDTH:0]   max_abs_err,
   output logic [ACC_W-1:0] sum_abs_err,
   output logic [WIDTH-1:0] worst_a,
   output logic [WIDTH-1:0] worst_b
`ifdef ERR_SWEEP_BITFLIP_EN
   ,
   output logic [(WIDTH+1)*CNT_W-1:0] bit_err_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;

   localparam logic [WIDTH-1:0] OP_ONE  = 1;
   localparam logic [WIDTH-1:0] OP_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   state_e           state_q, state_d;
   logic             startAccept, sweepStep, lastVec;
   logic             drainCnt_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             s1Valid_q;
   logic [WIDTH:0]   s1Sum_q, s1Exact_q;
   logic [WIDTH-1:0] s1A_q, s1B_q;
   logic [WIDTH:0]   exactSum, absErr;
   logic [CNT_W-1:0] errCount_q;
   logic [WIDTH:0]   maxErr_q;
   logic [ACC_W-1:0] sumErr_q;
   logic [WIDTH-1:0] worstA_q, worstB_q;

   assign lastVec  = (a_q == OP_MAX) && (b_q == OP_MAX);
   assign exactSum = {1'b0, a_q} + {1'b0, b_q};
   assign absErr   = (s1Sum_q >= s1Exact_q) ? (s1Sum_q - s1Exact_q) : (s1Exact_q - s1Sum_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // DRAIN lasts two cycles so the final vector clears both pipeline stages before done.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SWEEP;
         SWEEP:   if (lastVec) state_d = DRAIN;
         DRAIN:   if (drainCnt_q) state_d = DONE;
         DONE:    if (start) state_d = SWEEP;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      startAccept = 1'b0;
      sweepStep   = 1'b0;
      case (state_q)
         IDLE:    startAccept = start;
         SWEEP:   begin busy = 1'b1; sweepStep = 1'b1; end
         DRAIN:   busy = 1'b1;
         DONE:    begin done = 1'b1; startAccept = start; end
         default: ;
      endcase
   end

   // Stage 1 captures the presented vector; stage 2 folds it into the metrics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drainCnt_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         s1Valid_q  <= 1'b0;
         s1Sum_q    <= '0;
         s1Exact_q  <= '0;
         s1A_q      <= '0;
         s1B_q      <= '0;
         errCount_q <= '0;
         maxErr_q   <= '0;
         sumErr_q   <= '0;
         worstA_q   <= '0;
         worstB_q   <= '0;
      end else if (startAccept) begin
         drainCnt_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         s1Valid_q  <= 1'b0;
         errCount_q <= '0;
         maxErr_q   <= '0;
         sumErr_q   <= '0;
         worstA_q   <= '0;
         worstB_q   <= '0;
      end else begin
         s1Valid_q  <= sweepStep;
         drainCnt_q <= (state_q == DRAIN) ? ~drainCnt_q : 1'b0;
         if (sweepStep) begin
            s1Sum_q   <= dut_sum;
            s1Exact_q <= exactSum;
            s1A_q     <= a_q;
            s1B_q     <= b_q;
            if (!lastVec) begin
               b_q <= b_q + OP_ONE;
               if (b_q == OP_MAX) a_q <= a_q + OP_ONE;
            end
         end
         if (s1Valid_q) begin
            if (absErr != '0) errCount_q <= errCount_q + CNT_ONE;
            sumErr_q <= sumErr_q + {{(ACC_W-WIDTH-1){1'b0}}, absErr};
            if (absErr > maxErr_q) begin
               maxErr_q <= absErr;
               worstA_q <= s1A_q;
               worstB_q <= s1B_q;
            end
         end
      end
   end

   assign dut_a       = a_q;
   assign dut_b       = b_q;
   assign err_count   = errCount_q;
   assign max_abs_err = maxErr_q;
   assign sum_abs_err = sumErr_q;
   assign worst_a     = worstA_q;
   assign worst_b     = worstB_q;

`ifdef ERR_SWEEP_BITFLIP_EN
   logic [CNT_W-1:0] bitCnt_q [WIDTH+1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k <= WIDTH; k++) bitCnt_q[k] <= '0;
      end else if (startAccept) begin
         for (int k = 0; k <= WIDTH; k++) bitCnt_q[k] <= '0;
      end else if (s1Valid_q) begin
         for (int k = 0; k <= WIDTH; k++) begin
            if (s1Sum_q[k] != s1Exact_q[k]) bitCnt_q[k] <= bitCnt_q[k] + CNT_ONE;
         end
      end
   end

   for (genvar g = 0; g <= WIDTH; g++) begin : gBitOut
      assign bit_err_cnt[g*CNT_W +: CNT_W] = bitCnt_q[g];
   end
`endif

endmodule

// File: tb/tb_adder_err_sweep.sv
// Bench for adder_err_sweep: a 4-bit instance swept against randomized approximate adders
// scored by a loop-based reference model, and an 8-bit instance swept against an MSB-dropping adder.

module tb_adder_err_sweep;

   logic clk = 1'b0;
   logic rst;
   logic start4, start8;

   logic       busy4, done4;
   logic [3:0] a4, b4, wa4, wb4;
   logic [4:0] sum4, max4;
   logic [8:0] err4;
   logic [12:0] acc4;

   logic        busy8, done8;
   logic [7:0]  a8, b8, wa8, wb8, low8;
   logic [8:0]  sum8, max8;
   logic [16:0] err8;
   logic [24:0] acc8;

`ifdef ERR_SWEEP_BITFLIP_EN
   logic [5*9-1:0]  bits4;
   logic [9*17-1:0] bits8;
`endif

   int         mode4;
   int         k4;
   logic [4:0] lut4 [256];
   int         nComp = 0;
   int         nFail = 0;

   always #5 clk = ~clk;

   adder_err_sweep #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
      .dut_a(a4), .dut_b(b4), .dut_sum(sum4), .err_count(err4),
      .max_abs_err(max4), .sum_abs_err(acc4), .worst_a(wa4), .worst_b(wb4)
`ifdef ERR_SWEEP_BITFLIP_EN
      , .bit_err_cnt(bits4)
`endif
   );

   adder_err_sweep #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
      .dut_a(a8), .dut_b(b8), .dut_sum(sum8), .err_count(err8),
      .max_abs_err(max8), .sum_abs_err(acc8), .worst_a(wa8), .worst_b(wb8)
`ifdef ERR_SWEEP_BITFLIP_EN
      , .bit_err_cnt(bits8)
`endif
   );

   // Lower-part-OR adder: low k bits ORed, upper bits added exactly.
   function automatic int loa(input int a, input int b, input int k);
      return (((a >> k) + (b >> k)) << k) | ((a | b) & ((1 << k) - 1));
   endfunction

   function automatic int approxRef(input int mode, input int a, input int b);
      case (mode)
         0:       return a + b;
         1:       return int'(lut4[a*16 + b]);
         2:       return loa(a, b, k4);
         default: return 0;
      endcase
   endfunction

   // Stand-in for the external approximate adder netlists.
   always_comb begin
      case (mode4)
         0:       sum4 = {1'b0, a4} + {1'b0, b4};
         1:       sum4 = lut4[{a4, b4}];
         2:       sum4 = 5'(loa(int'(a4), int'(b4), k4));
         default: sum4 = '0;
      endcase
   end

   assign low8 = a8 + b8;
   assign sum8 = {1'b0, low8};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nComp++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One full 4-bit sweep; optional start pulses at given cycles and an optional mid-sweep reset.
   task automatic applyStimulus(input string tag, input int pulseA, input int pulseB, input int rstAt);
      int errE, maxE, sumE, waE, wbE, s, x, e, doneAt;
      int bitE [5];
      errE = 0; maxE = 0; sumE = 0; waE = 0; wbE = 0; doneAt = -1;
      for (int k = 0; k < 5; k++) bitE[k] = 0;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            s = approxRef(mode4, a, b);
            x = a + b;
            e = (s > x) ? s - x : x - s;
            if (e != 0) errE++;
            sumE += e;
            if (e > maxE) begin maxE = e; waE = a; wbE = b; end
            for (int k = 0; k < 5; k++) if (((s ^ x) >> k) & 1) bitE[k]++;
         end
      end

      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      checkOutput({tag, "_busy_at_accept"}, 64'(busy4), 64'd1);
      checkOutput({tag, "_done_cleared"}, 64'(done4), 64'd0);
      checkOutput({tag, "_err_cleared"}, 64'(err4), 64'd0);
      checkOutput({tag, "_max_cleared"}, 64'(max4), 64'd0);
      checkOutput({tag, "_vec0"}, 64'({a4, b4}), 64'd0);

      for (int c = 1; c <= 400; c++) begin
         if (c == pulseA || c == pulseB) start4 = 1'b1;
         tick();
         start4 = 1'b0;
         if (c == rstAt) begin
            rst = 1'b1;
            #1;
            checkOutput({tag, "_rst_busy"}, 64'(busy4), 64'd0);
            checkOutput({tag, "_rst_done"}, 64'(done4), 64'd0);
            checkOutput({tag, "_rst_ops"}, 64'({a4, b4}), 64'd0);
            checkOutput({tag, "_rst_metrics"}, 64'({err4, max4, acc4, wa4, wb4}), 64'd0);
            tick();
            rst = 1'b0;
            tick();
            checkOutput({tag, "_rst_idle"}, 64'({busy4, done4}), 64'd0);
            return;
         end
         if (c == 1 || c == 2 || c == 16) begin
            checkOutput({tag, "_vec_a"}, 64'(a4), 64'(c / 16));
            checkOutput({tag, "_vec_b"}, 64'(b4), 64'(c % 16));
         end
         if (done4) begin
            doneAt = c;
            break;
         end
      end

      checkOutput({tag, "_done_latency"}, 64'(doneAt), 64'd258);
      checkOutput({tag, "_busy_low"}, 64'(busy4), 64'd0);
      checkOutput({tag, "_err_count"}, 64'(err4), 64'(errE));
      checkOutput({tag, "_max_abs_err"}, 64'(max4), 64'(maxE));
      checkOutput({tag, "_sum_abs_err"}, 64'(acc4), 64'(sumE));
      checkOutput({tag, "_worst_a"}, 64'(wa4), 64'(waE));
      checkOutput({tag, "_worst_b"}, 64'(wb4), 64'(wbE));
      checkOutput({tag, "_last_held"}, 64'({a4, b4}), 64'hFF);
`ifdef ERR_SWEEP_BITFLIP_EN
      for (int k = 0; k < 5; k++)
         checkOutput($sformatf("%s_bitcnt%0d", tag, k), 64'(bits4[k*9 +: 9]), 64'(bitE[k]));
`endif
      tick();
      checkOutput({tag, "_done_hold"}, 64'({busy4, done4}), 64'd1);
      checkOutput({tag, "_err_hold"}, 64'(err4), 64'(errE));
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int doneAt8;
      rst = 1'b1;
      start4 = 1'b0;
      start8 = 1'b0;
      mode4 = 0;
      k4 = 1;
      for (int i = 0; i < 256; i++) lut4[i] = '0;
      repeat (2) tick();
      checkOutput("reset4_ctrl", 64'({busy4, done4}), 64'd0);
      checkOutput("reset4_ops", 64'({a4, b4}), 64'd0);
      checkOutput("reset4_metrics", 64'({err4, max4, acc4, wa4, wb4}), 64'd0);
      checkOutput("reset8_ctrl", 64'({busy8, done8}), 64'd0);
      checkOutput("reset8_ops", 64'({a8, b8}), 64'd0);
      checkOutput("reset8_metrics", 64'({max8, err8, wa8, wb8}), 64'd0);
      checkOutput("reset8_acc", 64'(acc8), 64'd0);
      rst = 1'b0;
      tick();

      mode4 = 1;
      for (int i = 0; i < 256; i++) lut4[i] = 5'($urandom_range(0, 31));
      applyStimulus("lut_a", 0, 0, 0);

      mode4 = 0;
      applyStimulus("exact", 0, 0, 0);

      mode4 = 2;
      k4 = $urandom_range(1, 3);
      applyStimulus("loa", 10, 200, 0);

      mode4 = 3;
      applyStimulus("stuck0", 0, 258, 0);

      mode4 = 1;
      for (int i = 0; i < 256; i++) lut4[i] = 5'($urandom_range(0, 31));
      applyStimulus("lut_rst", 0, 0, 100);
      applyStimulus("lut_b", 0, 0, 0);

      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      checkOutput("w8_busy_at_accept", 64'(busy8), 64'd1);
      checkOutput("w8_vec0", 64'({a8, b8}), 64'd0);
      doneAt8 = -1;
      for (int c = 1; c <= 70000; c++) begin
         if (c == 10 || c == 40000) start8 = 1'b1;
         tick();
         start8 = 1'b0;
         if (c == 1) checkOutput("w8_vec1", 64'({a8, b8}), 64'h0001);
         if (c == 256) checkOutput("w8_vec256", 64'({a8, b8}), 64'h0100);
         if (done8) begin
            doneAt8 = c;
            break;
         end
      end
      checkOutput("w8_done_latency", 64'(doneAt8), 64'd65538);
      checkOutput("w8_busy_low", 64'(busy8), 64'd0);
      checkOutput("w8_err_count", 64'(err8), 64'd32640);
      checkOutput("w8_max_abs_err", 64'(max8), 64'd256);
      checkOutput("w8_sum_abs_err", 64'(acc8), 64'd8355840);
      checkOutput("w8_worst_a", 64'(wa8), 64'd1);
      checkOutput("w8_worst_b", 64'(wb8), 64'd255);
      checkOutput("w8_last_held", 64'({a8, b8}), 64'hFFFF);
`ifdef ERR_SWEEP_BITFLIP_EN
      for (int k = 0; k < 9; k++)
         checkOutput($sformatf("w8_bitcnt%0d", k), 64'(bits8[k*17 +: 17]), (k == 8) ? 64'd32640 : 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
      $finish;
   end

endmodule
